// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester A/B and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if;
    logic        a_req;
    logic        a_wr;
    logic        a_wide;
    logic [15:0] a_addr;
    logic [15:0] a_din;
    logic        a_gnt;
    logic        a_rvalid;
    logic [15:0] a_rdata;

    logic        b_req;
    logic        b_lock;
    logic        b_wr;
    logic        b_wide;
    logic [15:0] b_addr;
    logic [15:0] b_din;
    logic        b_gnt;
    logic        b_rvalid;
    logic [15:0] b_rdata;

    logic        mem_en;
    logic        mem_wr;
    logic        mem_wide;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    modport slave (
        input  a_req, a_wr, a_wide, a_addr, a_din,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_lock, b_wr, b_wide, b_addr, b_din,
        output b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_wr, mem_wide, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output a_req, a_wr, a_wide, a_addr, a_din,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_lock, b_wr, b_wide, b_addr, b_din,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_wr, mem_wide, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory port arbiter, A priority, B starvation guard and locked bursts
module mem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int SW = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
    localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_TRIP = SW'(STARVE_MAX - 2);
    localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        PRI_A   = 2'd0,
        PRI_B   = 2'd1,
        BURST_B = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   starve_cnt;
    logic [BW-1:0]   burst_cnt;
    logic            a_gnt;
    logic            b_gnt;
    logic            starve_hit;
    logic            a_rvalid;
    logic            b_rvalid;
    logic [15:0]     a_hold;
    logic [15:0]     b_hold;
    logic            mem_en;
    logic            mem_wr;
    logic            mem_wide;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PRI_A;
        end else begin
            state <= state_nx;
        end
    end

    // The counter holds completed waits; this cycle's wait makes STARVE_MAX-1,
    // so B owns the STARVE_MAX-th cycle.
    assign starve_hit = bus.b_req && !b_gnt && (starve_cnt == STARVE_TRIP);

    always_comb begin
        state_nx = state;
        if (b_gnt && bus.b_lock && (burst_cnt < BURST_LAST)) begin
            state_nx = BURST_B;
        end else if (state != PRI_A) begin
            if (b_gnt || !bus.b_req) begin
                state_nx = PRI_A;
            end
        end else if (starve_hit) begin
            state_nx = PRI_B;
        end
    end

    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_wide = 1'b0;
        mem_addr = 16'h0000;
        mem_din  = 16'h0000;
        if (!reset) begin
            if (state == PRI_A) begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req && !bus.a_req;
            end else begin
                b_gnt = bus.b_req;
                a_gnt = bus.a_req && !bus.b_req;
            end
        end
        if (a_gnt) begin
            mem_en   = 1'b1;
            mem_wr   = bus.a_wr;
            mem_wide = bus.a_wide;
            mem_addr = bus.a_addr;
            mem_din  = bus.a_din;
        end else if (b_gnt) begin
            mem_en   = 1'b1;
            mem_wr   = bus.b_wr;
            mem_wide = bus.b_wide;
            mem_addr = bus.b_addr;
            mem_din  = bus.b_din;
        end
    end

    // burst_cnt counts every grant of the current locked run, including the one that opens it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            if (!bus.b_req || b_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_SAT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (state_nx == PRI_A) begin
                burst_cnt <= '0;
            end else if (b_gnt) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_hold   <= 16'h0000;
            b_hold   <= 16'h0000;
        end else begin
            a_rvalid <= a_gnt && !bus.a_wr;
            b_rvalid <= b_gnt && !bus.b_wr;
            if (a_rvalid) begin
                a_hold <= bus.mem_dout;
            end
            if (b_rvalid) begin
                b_hold <= bus.mem_dout;
            end
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid;
    assign bus.b_rvalid = b_rvalid;
    assign bus.a_rdata  = a_rvalid ? bus.mem_dout : a_hold;
    assign bus.b_rdata  = b_rvalid ? bus.mem_dout : b_hold;
    assign bus.mem_en   = mem_en;
    assign bus.mem_wr   = mem_wr;
    assign bus.mem_wide = mem_wide;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(8), .MAX_BURST(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-organised memory, one-cycle read latency.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            mem[8'h80] <= 16'hBEEF;
        end else if (bus.mem_en) begin
            if (bus.mem_wr) begin
                if (bus.mem_wide) mem[bus.mem_addr[8:1]] <= bus.mem_din;
                else if (bus.mem_addr[0]) mem[bus.mem_addr[8:1]][15:8] <= bus.mem_din[7:0];
                else mem[bus.mem_addr[8:1]][7:0] <= bus.mem_din[7:0];
            end else begin
                bus.mem_dout <= mem[bus.mem_addr[8:1]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_req  = 1'b0; bus.a_wr = 1'b0; bus.a_wide = 1'b0;
        bus.a_addr = 16'h0; bus.a_din = 16'h0;
        bus.b_req  = 1'b0; bus.b_lock = 1'b0; bus.b_wr = 1'b0; bus.b_wide = 1'b0;
        bus.b_addr = 16'h0; bus.b_din = 16'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        reset = 1'b1;
        bus.a_req = 1'b1;
        @(negedge clk);
        check("rst_a_gnt", bus.a_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_a_rvalid", bus.a_rvalid, 0);
        check("rst_b_rvalid", bus.b_rvalid, 0);
        check("rst_a_rdata", bus.a_rdata, 0);

        // 1: single A wide read of 0x0100
        next_cycle();
        reset = 1'b0;
        bus.a_req = 1'b1; bus.a_wide = 1'b1; bus.a_addr = 16'h0100;
        @(negedge clk);
        check("t1_a_gnt", bus.a_gnt, 1);
        check("t1_mem_addr", bus.mem_addr, 16'h0100);
        check("t1_mem_wide", bus.mem_wide, 1);
        next_cycle();
        bus.a_req = 1'b0;
        @(negedge clk);
        check("t1_a_rvalid", bus.a_rvalid, 1);
        check("t1_a_rdata", bus.a_rdata, 16'hBEEF);
        check("t1_idle_en", bus.mem_en, 0);
        next_cycle();
        @(negedge clk);
        check("t1_rvalid_off", bus.a_rvalid, 0);
        check("t1_rdata_hold", bus.a_rdata, 16'hBEEF);

        // 2: both requesting continuously -> 7 A grants then 1 B grant
        next_cycle();
        bus.a_req = 1'b1; bus.a_addr = 16'h0100; bus.a_wide = 1'b1;
        bus.b_req = 1'b1; bus.b_addr = 16'h0020; bus.b_wide = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("t2_a_gnt_c%0d", c), bus.a_gnt, (c % 8 != 0));
            check($sformatf("t2_b_gnt_c%0d", c), bus.b_gnt, (c % 8 == 0));
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        check("t2_idle_en", bus.mem_en, 0);

        // 3: locked B burst of 20, A arrives at word 3
        next_cycle();
        bus.b_req = 1'b1; bus.b_lock = 1'b1; bus.b_addr = 16'h0040; bus.b_wide = 1'b1;
        bus.a_addr = 16'h0100; bus.a_wide = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            if (c == 3) bus.a_req = 1'b1;
            @(negedge clk);
            check($sformatf("t3_b_gnt_c%0d", c), bus.b_gnt, (c <= 16 || c == 24));
            check($sformatf("t3_a_gnt_c%0d", c), bus.a_gnt, (c >= 17 && c <= 23));
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        next_cycle();

        // 4: A write then B read of the same word
        bus.a_req = 1'b1; bus.a_wr = 1'b1; bus.a_wide = 1'b1;
        bus.a_addr = 16'h0010; bus.a_din = 16'h1234;
        @(negedge clk);
        check("t4_a_gnt", bus.a_gnt, 1);
        check("t4_mem_wr", bus.mem_wr, 1);
        check("t4_mem_din", bus.mem_din, 16'h1234);
        next_cycle();
        clear_inputs();
        bus.b_req = 1'b1; bus.b_wide = 1'b1; bus.b_addr = 16'h0010;
        @(negedge clk);
        check("t4_b_gnt", bus.b_gnt, 1);
        check("t4_b_mem_wr", bus.mem_wr, 0);
        check("t4_wr_no_rvalid", bus.a_rvalid, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("t4_b_rvalid", bus.b_rvalid, 1);
        check("t4_b_rdata", bus.b_rdata, 16'h1234);
        check("t4_a_rvalid", bus.a_rvalid, 0);
        next_cycle();

        // 6: burst abandoned after 3 words, then a fresh full-length burst
        bus.b_req = 1'b1; bus.b_lock = 1'b1; bus.b_addr = 16'h0040; bus.b_wide = 1'b1;
        bus.a_addr = 16'h0100; bus.a_wide = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("t6_pre_b_gnt_c%0d", c), bus.b_gnt, 1);
            next_cycle();
        end
        bus.b_req = 1'b0;
        @(negedge clk);
        check("t6_withdraw_en", bus.mem_en, 0);
        next_cycle();
        bus.b_req = 1'b1; bus.a_req = 1'b1;
        @(negedge clk);
        check("t6_pri_a_a_gnt", bus.a_gnt, 1);
        check("t6_pri_a_b_gnt", bus.b_gnt, 0);
        next_cycle();
        bus.a_req = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            check($sformatf("t6_b_gnt_c%0d", c), bus.b_gnt, (c <= 16));
            check($sformatf("t6_a_gnt_c%0d", c), bus.a_gnt, (c == 17));
            next_cycle();
            bus.a_req = 1'b1;
        end
        clear_inputs();
        @(negedge clk);
        next_cycle();

        // 5: reset right after a locked B read grant
        bus.b_req = 1'b1; bus.b_lock = 1'b1; bus.b_addr = 16'h0010; bus.b_wide = 1'b1;
        @(negedge clk);
        check("t5_b_gnt", bus.b_gnt, 1);
        next_cycle();
        bus.b_req = 1'b0;
        reset = 1'b1;
        bus.a_req = 1'b1; bus.a_addr = 16'h0100; bus.a_wide = 1'b1;
        @(negedge clk);
        check("t5_rst_b_rvalid", bus.b_rvalid, 0);
        check("t5_rst_b_rdata", bus.b_rdata, 0);
        check("t5_rst_mem_en", bus.mem_en, 0);
        check("t5_rst_a_gnt", bus.a_gnt, 0);
        next_cycle();
        reset = 1'b0;
        bus.b_req = 1'b1;
        @(negedge clk);
        check("t5_post_a_gnt", bus.a_gnt, 1);
        check("t5_post_b_gnt", bus.b_gnt, 0);
        check("t5_post_b_rvalid", bus.b_rvalid, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("t5_a_rvalid", bus.a_rvalid, 1);
        check("t5_a_rdata", bus.a_rdata, 16'hBEEF);
        check("t5_b_rvalid_quiet", bus.b_rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
